// File: rtl/dmem_ctrl.sv
// Data-memory port controller: valid/ready LSU requests to a single-port BRAM
// with byte/half/word lanes, load extension, parametrised read latency and error reporting.
module dmem_ctrl #(
  parameter int ADDR_W   = 20,
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_adr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_we,
  output logic [31:0]       mem_din,
  input  logic [31:0]       mem_dout
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_e;

  state_e              state_q, state_d;
  logic [1:0]          cnt_q, cnt_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [3:0]          mem_we_q, mem_we_d;
  logic [31:0]         mem_din_q, mem_din_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                err_q, err_d;
  logic [1:0]          lo_q, lo_d;
  logic [1:0]          size_q, size_d;
  logic                uns_q, uns_d;
  logic                we_q, we_d;

  logic                accept, req_err, misalign, range_err;
  logic [3:0]          we_pat;
  logic [31:0]         din_pat, lane_b, ext;
  logic [15:0]         lane_h;

  assign req_ready = (state_q == IDLE) || (state_q == RESP);
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign mem_addr  = mem_addr_q;
  assign mem_we    = mem_we_q;
  assign mem_din   = mem_din_q;
  assign accept    = req_valid && req_ready;

  // Request decode: alignment, range, lane enables and replicated store data
  always_comb begin
    range_err = (req_adr >> (ADDR_W + 2)) != 32'd0;
    misalign  = 1'b0;
    we_pat    = 4'b1111;
    din_pat   = req_wdata;
    case (req_size)
      2'b00: begin
        we_pat  = 4'b0001 << req_adr[1:0];
        din_pat = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        misalign = req_adr[0];
        we_pat   = 4'b0011 << req_adr[1:0];
        din_pat  = {2{req_wdata[15:0]}};
      end
      2'b10:   misalign = req_adr[1:0] != 2'b00;
      default: misalign = 1'b1;
    endcase
    req_err = misalign || range_err;
  end

  // Load lane select and extension from the held request attributes
  always_comb begin
    lane_b = mem_dout >> {lo_q, 3'b000};
    lane_h = lo_q[1] ? mem_dout[31:16] : mem_dout[15:0];
    case (size_q)
      2'b00:   ext = uns_q ? {24'd0, lane_b[7:0]} : {{24{lane_b[7]}}, lane_b[7:0]};
      2'b01:   ext = uns_q ? {16'd0, lane_h} : {{16{lane_h[15]}}, lane_h};
      default: ext = mem_dout;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mem_addr_d = mem_addr_q;
    mem_we_d   = 4'b0000;
    mem_din_d  = mem_din_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    lo_d       = lo_q;
    size_d     = size_q;
    uns_d      = uns_q;
    we_d       = we_q;
    case (state_q)
      ACCESS: begin
        if (we_q) begin
          state_d = RESP;
          rdata_d = 32'd0;
          err_d   = 1'b0;
        end else begin
          state_d = WAIT;
          cnt_d   = 2'(READ_LAT - 1);
        end
      end
      WAIT: begin
        // Last wait cycle: BRAM output is valid for the address presented in ACCESS
        if (cnt_q == 2'd0) begin
          state_d = RESP;
          rdata_d = ext;
          err_d   = 1'b0;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (accept) begin
      if (req_err) begin
        state_d = RESP;
        err_d   = 1'b1;
        rdata_d = 32'd0;
      end else begin
        state_d    = ACCESS;
        mem_addr_d = req_adr[ADDR_W+1:2];
        lo_d       = req_adr[1:0];
        size_d     = req_size;
        uns_d      = req_unsigned;
        we_d       = req_we;
        if (req_we) begin
          mem_we_d  = we_pat;
          mem_din_d = din_pat;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      cnt_q      <= 2'd0;
      mem_addr_q <= '0;
      mem_we_q   <= 4'b0000;
      mem_din_q  <= 32'd0;
      rdata_q    <= 32'd0;
      err_q      <= 1'b0;
      lo_q       <= 2'd0;
      size_q     <= 2'd0;
      uns_q      <= 1'b0;
      we_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mem_addr_q <= mem_addr_d;
      mem_we_q   <= mem_we_d;
      mem_din_q  <= mem_din_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
      lo_q       <= lo_d;
      size_q     <= size_d;
      uns_q      <= uns_d;
      we_q       <= we_d;
    end
  end

endmodule
